// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the fetch stage of the 32-bit
//               MIPS-style datapath.
//               - RESET_PC_DEFAULT : default fetch address after reset
//               - NOP_INSTR        : encoding used for IF/ID bubbles
//               - pc_sel_t         : next-PC source selected each cycle
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned PC_W             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_HOLD   = 2'd3
  } pc_sel_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/next_pc_mux.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_mux
// Description : Combinational next-PC selection. Forms the branch target
//               (PC+4 of the branch plus the pre-shifted offset), the jump
//               target (region bits of PC+4 concatenated with the index) and
//               picks one by priority: jump > branch > stall > sequential.
// Ports       : pc, pc_plus4       - current PC and its successor
//               stall              - hold request from hazard logic
//               branch_taken       - taken branch resolved in ID
//               branch_pc4         - PC+4 of the ID instruction (branch/jump)
//               branch_offset      - sign-extended, shifted-left-2 immediate
//               jump, jump_index   - j/jal in ID and its 26-bit index
//               sel                - chosen source
//               next_pc            - word-aligned next fetch address
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output pc_sel_t     sel,
  output logic [31:0] next_pc
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] raw_next;

  // Offset low bits are don't-care; clearing them before the add keeps any
  // stray bits from rippling a carry into bit 2.
  assign branch_target = branch_pc4 + (branch_offset & ALIGN_MASK);
  assign jump_target   = {branch_pc4[31:28], jump_index, 2'b00};

  // A redirect outranks stall: the instruction being held is on the wrong
  // path anyway once ID has resolved a control transfer.
  always_comb begin
    sel = PC_SEQ;
    if (jump)              sel = PC_JUMP;
    else if (branch_taken) sel = PC_BRANCH;
    else if (stall)        sel = PC_HOLD;
  end

  always_comb begin
    raw_next = pc_plus4;
    case (sel)
      PC_JUMP:   raw_next = jump_target;
      PC_BRANCH: raw_next = branch_target;
      PC_HOLD:   raw_next = pc;
      default:   raw_next = pc_plus4;
    endcase
  end

  // Every value loaded into the PC is forced word-aligned.
  assign next_pc = raw_next & ALIGN_MASK;

endmodule : next_pc_mux
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage
// Description : Program counter, next-PC selection and IF/ID pipeline
//               register. A redirect (jump or taken branch) loads the target
//               into the PC and flushes IF/ID, giving exactly one bubble.
// Ports       : clk, reset                 - clock, async active-high reset
//               stall                      - hold PC and IF/ID
//               branch_taken, branch_pc4,
//               branch_offset              - branch redirect request
//               jump, jump_index           - jump redirect request
//               imem_rdata                 - instruction at pc (comb. imem)
//               pc, pc_plus4               - fetch address and its successor
//               if_id_instr, if_id_pc4,
//               if_id_valid                - IF/ID register contents
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter int unsigned n        = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_pc4,
  input  logic [n-1:0] branch_offset,
  input  logic         jump,
  input  logic [25:0]  jump_index,
  input  logic [31:0]  imem_rdata,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic [31:0]  if_id_instr,
  output logic [n-1:0] if_id_pc4,
  output logic         if_id_valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  pc_sel_t     sel;
  logic [31:0] next_pc;

  assign pc_plus4 = pc + 32'd4;

  next_pc_mux u_next_pc_mux (
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_pc4    (branch_pc4),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .sel           (sel),
    .next_pc       (next_pc)
  );

  // On PC_HOLD the mux already returns pc, so the PC can load unconditionally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC_ALIGNED;
    end else begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      case (sel)
        PC_JUMP, PC_BRANCH: begin
          // Instruction fetched this cycle is on the wrong path: squash it.
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end
        PC_HOLD: begin
          if_id_instr <= if_id_instr;
          if_id_valid <= if_id_valid;
        end
        default: begin
          if_id_instr <= imem_rdata;
          if_id_pc4   <= pc_plus4;
          if_id_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule : pc_fetch_stage
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_stage
// Description : Directed, self-checking bench for pc_fetch_stage. The
//               instruction memory is a combinational model: address 0
//               returns 32'h2008_0005, any other address A returns
//               {A[15:0], 16'hC0DE}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = (pc == 32'h0) ? 32'h2008_0005 : {pc[15:0], 16'hC0DE};

  pc_fetch_stage #(
    .n        (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_pc4    (branch_pc4),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    jump          = 1'b0;
    branch_pc4    = 32'h0;
    branch_offset = 32'h0;
    jump_index    = 26'h0;
  endtask

  task automatic branch_req(input logic [31:0] p4, input logic [31:0] off);
    branch_taken  = 1'b1;
    branch_pc4    = p4;
    branch_offset = off;
  endtask

  initial begin
    reset = 1'b1;
    idle_ctrl();
    #2;
    check("rst_pc",    pc,                  32'h0);
    check("rst_instr", if_id_instr,         32'h0);
    check("rst_pc4",   if_id_pc4,           32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_plus4", pc_plus4,            32'h4);

    // Reset release
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("e1_pc",    pc,                   32'h0000_0004);
    check("e1_instr", if_id_instr,          32'h2008_0005);
    check("e1_valid", {31'b0, if_id_valid}, 32'h1);
    check("e1_pc4",   if_id_pc4,            32'h0000_0004);
    tick();
    check("e2_pc",    pc,                   32'h0000_0008);
    check("e2_instr", if_id_instr,          32'h0004_C0DE);

    // Positive branch: 0x10 + 0x20
    branch_req(32'h0000_0010, 32'h0000_0020);
    tick();
    check("br_pc",    pc,                   32'h0000_0030);
    check("br_valid", {31'b0, if_id_valid}, 32'h0);
    check("br_instr", if_id_instr,          32'h0);
    idle_ctrl();
    tick();
    check("br_t_pc",    pc,                   32'h0000_0034);
    check("br_t_instr", if_id_instr,          32'h0030_C0DE);
    check("br_t_valid", {31'b0, if_id_valid}, 32'h1);
    check("br_t_pc4",   if_id_pc4,            32'h0000_0034);

    // Negative branch: 0x100 + (-8)
    branch_req(32'h0000_0100, 32'hFFFF_FFF8);
    tick();
    check("nbr_pc", pc, 32'h0000_00F8);

    // Offset low bits ignored: 0x10 + 0x23 -> 0x30
    branch_req(32'h0000_0010, 32'h0000_0023);
    tick();
    check("off_lsb_pc", pc, 32'h0000_0030);

    // Jump and branch together: jump wins
    branch_req(32'h4000_0008, 32'h0000_0020);
    jump       = 1'b1;
    jump_index = 26'h000_0040;
    tick();
    check("jmp_pc",    pc,                   32'h4000_0100);
    check("jmp_valid", {31'b0, if_id_valid}, 32'h0);
    check("jmp_instr", if_id_instr,          32'h0);
    idle_ctrl();

    // Reach pc = 0x20 with a real instruction in IF/ID, then stall 3 cycles
    branch_req(32'h0000_0010, 32'h0000_000C);
    tick();
    check("pre_st_pc", pc, 32'h0000_001C);
    idle_ctrl();
    tick();
    check("st0_pc", pc, 32'h0000_0020);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("st_pc",    pc,                   32'h0000_0020);
      check("st_instr", if_id_instr,          32'h001C_C0DE);
      check("st_pc4",   if_id_pc4,            32'h0000_0020);
      check("st_valid", {31'b0, if_id_valid}, 32'h1);
    end
    // Branch during stall redirects anyway
    branch_req(32'h0000_0080, 32'h0000_0040);
    tick();
    check("st_br_pc",    pc,                   32'h0000_00C0);
    check("st_br_valid", {31'b0, if_id_valid}, 32'h0);
    idle_ctrl();

    // Wrap-around
    branch_req(32'hFFFF_FFF0, 32'h0000_000C);
    tick();
    check("wr_pc",    pc,       32'hFFFF_FFFC);
    check("wr_plus4", pc_plus4, 32'h0000_0000);
    idle_ctrl();
    tick();
    check("wr_next_pc", pc,                   32'h0000_0000);
    check("wr_instr",   if_id_instr,          32'hFFFC_C0DE);
    check("wr_pc4",     if_id_pc4,            32'h0000_0000);
    check("wr_valid",   {31'b0, if_id_valid}, 32'h1);

    // Async reset mid-cycle with a redirect pending
    tick();
    check("pre_rst_pc", pc, 32'h0000_0004);
    branch_req(32'h0000_0200, 32'h0000_0010);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pc",    pc,                   32'h0);
    check("arst_valid", {31'b0, if_id_valid}, 32'h0);
    check("arst_instr", if_id_instr,          32'h0);
    tick();
    check("arst_hold_pc", pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_ctrl();
    tick();
    check("rel_pc",    pc,          32'h0000_0004);
    check("rel_instr", if_id_instr, 32'h2008_0005);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_pc_fetch_stage
`default_nettype wire

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program-counter register plus next-PC selection and IF/ID pipeline register for the 32-bit MIPS-style datapath.
- Directly downstream of the shift-left-by-2 unit: consumes its word-aligned branch offset, adds it to the branch instruction's PC+4, and redirects fetch.
- Also forms jump targets and handles stall and flush.
- Sits between the hazard/branch logic in ID and the instruction memory.

Parameters:
- n, 32, datapath/PC width in bits (the design is fixed at 32; other values are unsupported).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold PC and IF/ID register this cycle
- branch_taken  input  1  ID resolved a taken branch this cycle
- branch_pc4  input  n  PC+4 of the branch instruction in ID
- branch_offset  input  n  sign-extended immediate already shifted left by 2 (sl2 output)
- jump  input  1  ID holds a j/jal this cycle
- jump_index  input  26  instr[25:0] of the jump
- imem_rdata  input  32  instruction read at pc (combinational imem)
- pc  output  n  current fetch address to imem
- pc_plus4  output  n  pc + 4, combinational
- if_id_instr  output  32  registered instruction to ID
- if_id_pc4  output  n  registered PC+4 to ID
- if_id_valid  output  1  IF/ID register holds a real instruction

Behaviour:
- Reset (async, active-high, immediate on assertion):
  - pc = RESET_PC, if_id_instr = 32'h0 (nop), if_id_pc4 = 0, if_id_valid = 0.
- Reset deasserted: first posedge latches imem_rdata at RESET_PC into IF/ID and sets if_id_valid = 1.
- Next-PC priority, evaluated each posedge:
  1. jump: pc <= {branch_pc4[31:28], jump_index, 2'b00}. Jump shares the branch_pc4 bus; ID drives it with the jump's PC+4.
  2. branch_taken: pc <= branch_pc4 + branch_offset, modulo 2^n.
  3. stall: pc and IF/ID unchanged.
  4. Otherwise: pc <= pc + 4, modulo 2^n.
- Redirect (jump or branch_taken):
  - IF/ID is flushed: if_id_instr <= 0, if_id_valid <= 0.
  - Exactly one bubble; the instruction at the target is fetched the following cycle.
- Redirect overrides stall in the same cycle; the redirect and flush happen, and stall is ignored.
- jump and branch_taken both high: jump wins; the branch target is discarded.
- Normal advance: if_id_instr <= imem_rdata, if_id_pc4 <= pc_plus4, if_id_valid <= 1.
- Latency:
  - Redirect visible on pc one cycle after the request edge.
  - Target instruction reaches IF/ID two edges after the request.
- Alignment:
  - pc[1:0] is forced to 2'b00 on every load, including RESET_PC.
  - branch_offset[1:0] is ignored.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Negative offsets: two's-complement add, e.g. 32'h0000_0100 + 32'hFFFF_FFF8 = 32'h0000_00F8.
- Reset asserted mid-stall or mid-redirect: all state returns immediately to the reset values; the pending redirect is lost.
- pc_plus4 is purely combinational from pc.

Decomposition:
- Shared package (cpu_pkg):
  - constants RESET_PC_DEFAULT and NOP_INSTR = 32'h0;
  - typedef pc_sel_t enum {PC_SEQ, PC_BRANCH, PC_JUMP, PC_HOLD}.
- One natural sub-module: next_pc_mux. It is combinational: it computes the target adders, the jump concat and the priority select, and outputs pc_sel_t plus next_pc.
- Registers stay in pc_fetch_stage.

Test Plan:
- Reset release with RESET_PC = 0, imem returning 32'h2008_0005 at address 0:
  - after edge 1: pc = 4, if_id_instr = 32'h2008_0005, if_id_valid = 1;
  - after edge 2: pc = 8.
- branch_taken with branch_pc4 = 32'h0000_0010 and branch_offset = 32'h0000_0020: next pc = 32'h0000_0030, if_id_valid = 0 for one cycle.
- Negative branch with branch_pc4 = 32'h0000_0100 and branch_offset = 32'hFFFF_FFF8: pc = 32'h0000_00F8.
- jump and branch_taken together, with branch_pc4 = 32'h4000_0008 and jump_index = 26'h000_0040: pc = 32'h4000_0100 and the IF/ID register is flushed.
- stall held 3 cycles from pc = 32'h0000_0020: pc and if_id_* stay constant. Asserting branch_taken during the stall redirects regardless.
- Wrap test, pc = 32'hFFFF_FFFC with no control inputs: next pc = 0. Asserting reset mid-cycle: pc = RESET_PC and if_id_valid = 0 immediately, without waiting for a clock edge.
